// File: rtl/rail_monitor_pkg.sv
// rtl/rail_monitor_pkg.sv - shared constants, types and width helper for the rail monitor
package rail_monitor_pkg;

  localparam int SINC_ORDER = 3;
  localparam int RAIL_OUT_W = 16;

  typedef logic [RAIL_OUT_W-1:0] rail_word_t;

  // Integrator width that holds OSR^SINC_ORDER without ambiguity under modulo wrap
  function automatic int acc_w(input int osr);
    return SINC_ORDER * $clog2(osr) + 1;
  endfunction

endpackage

// File: rtl/rail_monitor_if.sv
// rtl/rail_monitor_if.sv - modulator pins, thresholds and telemetry outputs of the rail monitor
interface rail_monitor_if #(
  parameter int NUM_CH = 5,
  parameter int OUT_W  = 16
);
  logic                         mclk;
  logic [NUM_CH-1:0]            sdat;
  logic [NUM_CH-1:0][OUT_W-1:0] thr_hi;
  logic [NUM_CH-1:0][OUT_W-1:0] thr_lo;
  logic                         fault_clr;
  logic [NUM_CH-1:0][OUT_W-1:0] out_data;
  logic                         data_ready;
  logic [NUM_CH-1:0]            over_flag;
  logic [NUM_CH-1:0]            under_flag;
  logic                         mclk_lost;

  modport master (
    output mclk, sdat, thr_hi, thr_lo, fault_clr,
    input  out_data, data_ready, over_flag, under_flag, mclk_lost
  );

  modport slave (
    input  mclk, sdat, thr_hi, thr_lo, fault_clr,
    output out_data, data_ready, over_flag, under_flag, mclk_lost
  );
endinterface

// File: rtl/rail_monitor_sinc3.sv
// rtl/rail_monitor_sinc3.sv - one sinc3 decimator channel: integrators on tick, combs on dec, scaled output
module sinc3_channel
  import rail_monitor_pkg::*;
#(
  parameter int OSR   = 64,
  parameter int OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             dec_i,
  input  logic             clr_i,
  input  logic             sdat_i,
  output logic [OUT_W-1:0] scaled_o
);

  localparam int ACC_W  = acc_w(OSR);
  localparam int SH     = SINC_ORDER * $clog2(OSR) - OUT_W;
  localparam int SHR    = (SH >= 0) ? SH : 0;
  localparam int SHL    = (SH < 0) ? -SH : 0;
  localparam int WIDE_W = ACC_W + OUT_W;

  logic [ACC_W-1:0] int1_q, int2_q, int3_q, int1_d, int2_d, int3_d;
  logic [ACC_W-1:0] dly1_q, dly2_q, dly3_q, dly1_d, dly2_d, dly3_d;
  logic [ACC_W-1:0] c1, c2, c3;
  logic [WIDE_W-1:0] wide;

  assign c1 = int3_q - dly1_q;
  assign c2 = c1 - dly2_q;
  assign c3 = c2 - dly3_q;

  always_comb begin
    int1_d = int1_q;
    int2_d = int2_q;
    int3_d = int3_q;
    dly1_d = dly1_q;
    dly2_d = dly2_q;
    dly3_d = dly3_q;
    if (tick_i) begin
      int1_d = int1_q + ACC_W'(sdat_i);
      int2_d = int2_q + int1_q;
      int3_d = int3_q + int2_q;
    end
    if (dec_i) begin
      dly1_d = int3_q;
      dly2_d = c1;
      dly3_d = c2;
    end
    if (clr_i) begin
      int1_d = '0;
      int2_d = '0;
      int3_d = '0;
      dly1_d = '0;
      dly2_d = '0;
      dly3_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      int1_q <= '0;
      int2_q <= '0;
      int3_q <= '0;
      dly1_q <= '0;
      dly2_q <= '0;
      dly3_q <= '0;
    end else begin
      int1_q <= int1_d;
      int2_q <= int2_d;
      int3_q <= int3_d;
      dly1_q <= dly1_d;
      dly2_q <= dly2_d;
      dly3_q <= dly3_d;
    end
  end

  // Full-scale OSR^3 lands one count above the output range, hence the clamp
  assign wide     = (WIDE_W'(c3) >> SHR) << SHL;
  assign scaled_o = (|wide[WIDE_W-1:OUT_W]) ? '1 : wide[OUT_W-1:0];

endmodule

// File: rtl/rail_monitor.sv
// rtl/rail_monitor.sv - frame-aligned multi-channel sinc3 rail monitor with mclk watchdog
// Optional sticky threshold flags are built when RAIL_MONITOR_FAULT_EN is defined.
module rail_monitor
  import rail_monitor_pkg::*;
#(
  parameter int NUM_CH       = 5,
  parameter int OSR          = 64,
  parameter int OUT_W        = 16,
  parameter int MCLK_TIMEOUT = 1024
) (
  input logic           sclk,
  input logic           rst,
  rail_monitor_if.slave bus
);

  localparam int CNT_W = $clog2(OSR);
  localparam int WD_W  = $clog2(MCLK_TIMEOUT + 1);

  logic [2:0]                   mclk_sync_q;
  logic [NUM_CH-1:0]            sdat_s1_q, sdat_s2_q;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         dec_q, dec_d;
  logic [1:0]                   settle_q, settle_d;
  logic [WD_W-1:0]              wd_q, wd_d;
  logic [NUM_CH-1:0][OUT_W-1:0] out_data_q, scaled;
  logic                         data_ready_q;
  logic                         tick, lost, update;

  assign tick   = mclk_sync_q[1] & ~mclk_sync_q[2];
  assign lost   = (wd_q == WD_W'(MCLK_TIMEOUT));
  assign update = dec_q & (settle_q == 2'd2) & ~lost;

  // While mclk is lost the whole pipeline is held clear so recovery restarts settling
  always_comb begin
    cnt_d    = cnt_q;
    dec_d    = 1'b0;
    settle_d = settle_q;
    wd_d     = wd_q;
    if (tick)       wd_d = '0;
    else if (!lost) wd_d = wd_q + 1'b1;
    if (lost) begin
      cnt_d    = '0;
      settle_d = '0;
    end else begin
      if (tick) begin
        cnt_d = cnt_q + 1'b1;
        dec_d = (cnt_q == CNT_W'(OSR - 1));
      end
      if (dec_q && settle_q != 2'd2) settle_d = settle_q + 2'd1;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      mclk_sync_q  <= '0;
      sdat_s1_q    <= '0;
      sdat_s2_q    <= '0;
      cnt_q        <= '0;
      dec_q        <= 1'b0;
      settle_q     <= '0;
      wd_q         <= '0;
      out_data_q   <= '0;
      data_ready_q <= 1'b0;
    end else begin
      mclk_sync_q  <= {mclk_sync_q[1:0], bus.mclk};
      sdat_s1_q    <= bus.sdat;
      sdat_s2_q    <= sdat_s1_q;
      cnt_q        <= cnt_d;
      dec_q        <= dec_d;
      settle_q     <= settle_d;
      wd_q         <= wd_d;
      data_ready_q <= update;
      if (update) out_data_q <= scaled;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sinc3_channel #(.OSR(OSR), .OUT_W(OUT_W)) u_sinc (
      .clk_i   (sclk),
      .rst_i   (rst),
      .tick_i  (tick),
      .dec_i   (dec_q),
      .clr_i   (lost),
      .sdat_i  (sdat_s2_q[g]),
      .scaled_o(scaled[g])
    );
  end

`ifdef RAIL_MONITOR_FAULT_EN
  logic [NUM_CH-1:0] over_q, over_d, under_q, under_d;

  // A new violation in the clear cycle wins over fault_clr
  always_comb begin
    over_d  = bus.fault_clr ? '0 : over_q;
    under_d = bus.fault_clr ? '0 : under_q;
    if (update) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (scaled[i] > bus.thr_hi[i]) over_d[i]  = 1'b1;
        if (scaled[i] < bus.thr_lo[i]) under_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      over_q  <= '0;
      under_q <= '0;
    end else begin
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

  assign bus.over_flag  = over_q;
  assign bus.under_flag = under_q;
`else
  logic unused_fault;
  assign unused_fault   = ^{bus.thr_hi, bus.thr_lo, bus.fault_clr};
  assign bus.over_flag  = '0;
  assign bus.under_flag = '0;
`endif

  assign bus.out_data   = out_data_q;
  assign bus.data_ready = data_ready_q;
  assign bus.mclk_lost  = lost;

endmodule

// File: tb/tb_rail_monitor.sv
// tb/tb_rail_monitor.sv - directed self-checking bench for rail_monitor (sclk/8 modulator clock, OSR 64)
module tb_rail_monitor;
  import rail_monitor_pkg::*;

  localparam int NUM_CH       = 5;
  localparam int OSR          = 64;
  localparam int OUT_W        = 16;
  localparam int MCLK_TIMEOUT = 1024;
`ifdef RAIL_MONITOR_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  localparam logic [NUM_CH-1:0] OVR_EXP = FAULT_EN ? 5'b00100 : 5'b00000;
  localparam logic [NUM_CH-1:0] UND_EXP = FAULT_EN ? 5'b01000 : 5'b00000;

  localparam rail_word_t W_FULL = 16'd65535;
  localparam rail_word_t W_HALF = 16'd32768;
  localparam rail_word_t W_75   = 16'd49152;
  localparam rail_word_t W_25   = 16'd16384;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   mcnt = 0;
  bit   mclk_run = 1'b0;
  int   mode [NUM_CH];

  rail_monitor_if #(.NUM_CH(NUM_CH), .OUT_W(OUT_W)) bus ();

  rail_monitor #(
    .NUM_CH(NUM_CH), .OSR(OSR), .OUT_W(OUT_W), .MCLK_TIMEOUT(MCLK_TIMEOUT)
  ) dut (
    .sclk(sclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  function automatic logic pat(input int m, input int n);
    case (m)
      1:       return 1'b1;
      2:       return (n % 2) == 1;
      3:       return (n % 4) != 0;
      4:       return (n % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // mclk = sclk/8, sdat changes on the falling edge so it is stable at the rise
  initial begin
    bus.mclk = 1'b0;
    bus.sdat = '0;
    #2;
    for (int ch = 0; ch < NUM_CH; ch++) bus.sdat[ch] = pat(mode[ch], mcnt);
    forever begin
      #40;
      if (mclk_run) begin
        bus.mclk  = 1'b1;
        last_rise = cyc;
      end
      #40;
      bus.mclk = 1'b0;
      mcnt++;
      for (int ch = 0; ch < NUM_CH; ch++) bus.sdat[ch] = pat(mode[ch], mcnt);
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag, output int at);
    int  w;
    bit  seen;
    w    = 0;
    seen = 1'b0;
    while (!seen && w < 3000) begin
      @(negedge sclk);
      w++;
      seen = bus.data_ready;
    end
    at = cyc;
    check({tag, "_timeout"}, seen, 1);
  endtask

  task automatic check_words(input string tag, input int v0, input int v1, input int vr);
    check({tag, "_ch0"}, bus.out_data[0], v0);
    check({tag, "_ch1"}, bus.out_data[1], v1);
    for (int i = 2; i < NUM_CH; i++) check($sformatf("%s_ch%0d", tag, i), bus.out_data[i], vr);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got cycle %0d, expected finish earlier", cyc);
    $fatal(1);
  end

  initial begin : main
    int fr, t, t_prev, drc, lost_at, lastr;
    bus.fault_clr = 1'b0;
    bus.thr_hi    = '1;
    bus.thr_lo    = '0;
    mode[0] = 1;
    mode[1] = 0;
    for (int i = 2; i < NUM_CH; i++) mode[i] = 2;

    repeat (3) @(negedge sclk);
    for (int i = 0; i < NUM_CH; i++) check($sformatf("rst_out%0d", i), bus.out_data[i], 0);
    check("rst_ready", bus.data_ready, 0);
    check("rst_lost", bus.mclk_lost, 0);
    check("rst_over", bus.over_flag, 0);
    check("rst_under", bus.under_flag, 0);

    // Startup: third frame end is rise 192, seen 4 sclk later
    rst      = 1'b0;
    mclk_run = 1'b1;
    @(posedge bus.mclk);
    fr = cyc;
    wait_ready("first", t);
    check("first_latency", t - fr, 1532);
    check_words("first", W_FULL, 0, W_HALF);
    for (int k = 0; k < 2; k++) begin
      @(negedge sclk);
      check("ready_width", bus.data_ready, 0);
      t_prev = t;
      wait_ready("period", t);
      check("period", t - t_prev, 512);
      check_words("steady", W_FULL, 0, W_HALF);
    end

    // Watchdog: stop mclk for 1100 sclk cycles
    mclk_run = 1'b0;
    lastr    = last_rise;
    drc      = 0;
    lost_at  = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge sclk);
      if (bus.data_ready) drc++;
      if (bus.mclk_lost && lost_at == 0) lost_at = cyc;
    end
    check("wd_latency", lost_at - lastr, 1027);
    check("wd_no_ready", drc, 0);
    check("wd_lost_level", bus.mclk_lost, 1);
    check("wd_hold_ch0", bus.out_data[0], W_FULL);
    mclk_run = 1'b1;
    @(posedge bus.mclk);
    fr = cyc;
    repeat (8) @(negedge sclk);
    check("wd_recover", bus.mclk_lost, 0);
    wait_ready("wd_resume", t);
    check("wd_resume_latency", t - fr, 1540);
    check_words("wd_resume", W_FULL, 0, W_HALF);

    // Asynchronous reset mid-frame, then threshold scenario from a fresh start
    wait_ready("pre_rst", t);
    repeat (200) @(negedge sclk);
    mode[2]       = 3;
    bus.thr_hi[2] = 16'd40000;
    bus.thr_lo[3] = 16'd40000;
    #2 rst = 1'b1;
    #1;
    check("arst_out0", bus.out_data[0], 0);
    check("arst_out2", bus.out_data[2], 0);
    check("arst_ready", bus.data_ready, 0);
    @(negedge bus.mclk);
    @(negedge sclk);
    rst = 1'b0;
    @(posedge bus.mclk);
    fr = cyc;
    wait_ready("post_rst", t);
    check("post_rst_latency", t - fr, 1532);
    check("thr_ch2_75", bus.out_data[2], W_75);
    check("thr_ch3_50", bus.out_data[3], W_HALF);
    check("thr_over_set", bus.over_flag, OVR_EXP);
    check("thr_under_set", bus.under_flag, UND_EXP);

    mode[2] = 4;
    for (int k = 0; k < 4; k++) wait_ready("drop", t);
    check("drop_ch2_25", bus.out_data[2], W_25);
    check("drop_over_sticky", bus.over_flag, OVR_EXP);

    repeat (100) @(negedge sclk);
    bus.fault_clr = 1'b1;
    @(negedge sclk);
    bus.fault_clr = 1'b0;
    check("clr_over", bus.over_flag, 0);
    check("clr_under", bus.under_flag, 0);
    wait_ready("after_clr", t);
    check("after_clr_over", bus.over_flag, 0);
    check("after_clr_under", bus.under_flag, UND_EXP);

    // fault_clr high exactly on the next update edge while ch2 now violates
    bus.thr_hi[2] = 16'd10000;
    repeat (511) @(negedge sclk);
    bus.fault_clr = 1'b1;
    @(negedge sclk);
    bus.fault_clr = 1'b0;
    check("coincide_ready", bus.data_ready, 1);
    check("coincide_over", bus.over_flag, OVR_EXP);
    check("coincide_under", bus.under_flag, UND_EXP);
    check("coincide_ch2", bus.out_data[2], W_25);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rail_monitor.md
Name: rail_monitor

Overview:
- Multi-channel rail voltage/current monitor for delta-sigma modulator bitstreams, such as AMC1303-class isolated modulators.
- Each channel runs a sinc3 decimator. All channels share one decimation counter, so results are frame-aligned.
- Results are scaled to OUT_W bits and checked against per-channel high/low thresholds, with sticky fault flags.
- A watchdog detects loss of the modulator clock. The block sits between the modulator pins and the rover telemetry/protection logic.

Parameters:
- NUM_CH, 5, number of modulator channels.
- OSR, 64, decimation ratio. Must be a power of two, 8..256.
- OUT_W, 16, output word width.
- MCLK_TIMEOUT, 1024, number of sclk cycles without an mclk rising edge before mclk_lost asserts.

Ports:
- sclk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mclk  in  1  modulator clock, shared by all channels, asynchronous to sclk.
- sdat  in  NUM_CH  modulator bitstreams, one per channel.
- thr_hi  in  NUM_CH x OUT_W  per-channel over-limit threshold.
- thr_lo  in  NUM_CH x OUT_W  per-channel under-limit threshold.
- fault_clr  in  1  one-cycle pulse; clears all sticky flags.
- out_data  out  NUM_CH x OUT_W  latest scaled result per channel.
- data_ready  out  1  one-cycle pulse when out_data updates.
- over_flag  out  NUM_CH  sticky: result > thr_hi.
- under_flag  out  NUM_CH  sticky: result < thr_lo.
- mclk_lost  out  1  level; modulator clock absent.

Behaviour:
- Reset: all outputs are 0. All integrators, differentiators, counters and synchronisers are 0. The settle counter is cleared.
  - Reset is asynchronous assert and applies at any point mid-frame.
  - The first frame after reset starts fresh.
- Input capture:
  - mclk and sdat each pass through a 2-FF synchroniser.
  - A rising edge of synchronised mclk produces a one-cycle strobe `tick`.
  - sdat is sampled on `tick`. A sampled 1 maps to +1, a sampled 0 maps to 0 (unsigned density).
- Integrators (per channel):
  - Three cascaded integrators, each ACC_W = 3*log2(OSR)+1 bits wide, update on tick.
  - Modulo-2^ACC_W wrap is intended and exact.
- Decimation:
  - A shared counter of log2(OSR) bits increments on tick.
  - On the tick where it wraps from OSR-1 to 0, `dec` is raised for one cycle.
  - On `dec`, a three-stage comb (differentiator) runs on the last integrator output, mod 2^ACC_W. Result range is 0..OSR^3.
- Scaling:
  - SH = 3*log2(OSR) - OUT_W.
  - If SH >= 0, scaled = result >> SH. Otherwise scaled = result << -SH.
  - scaled is then saturated to 2^OUT_W - 1.
  - With the defaults, an all-ones stream gives 65535, 50 % density gives 32768, and all-zeros gives 0.
- Output timing:
  - Settle: the first 2 dec events after reset (or after mclk recovery) update nothing.
  - From the 3rd dec onward, scaled values register into out_data one sclk cycle after dec.
  - data_ready pulses high in that same cycle.
  - out_data holds between updates.
- Thresholds:
  - Compared on each out_data update using that update's values and the thr_* values present then.
  - over_flag[i] sets if scaled > thr_hi[i]. under_flag[i] sets if scaled < thr_lo[i].
  - Flags set in the same cycle as data_ready.
  - If fault_clr coincides with a set condition, set wins.
  - If thr_lo > thr_hi, both flags may set; this is legal.
- Watchdog:
  - A counter resets on tick and otherwise increments, saturating at MCLK_TIMEOUT.
  - When the counter reaches MCLK_TIMEOUT, mclk_lost = 1. The integrators, combs, decimation counter and settle counter are cleared, and data_ready is suppressed.
  - out_data and the sticky flags hold their values.
  - On the next tick, mclk_lost = 0 and the settle sequence restarts.
- Timing assumption: mclk frequency is at most sclk/4, so ticks are never lost by the synchroniser.

Optional Feature:
- Macro: RAIL_MONITOR_FAULT_EN.
- Defined: threshold comparison and sticky over_flag/under_flag are built as described above.
- Undefined: comparators and flag registers are omitted. over_flag and under_flag are tied to 0, and thr_hi, thr_lo and fault_clr are unused.
- out_data, data_ready and mclk_lost are identical in both builds.

Decomposition:
- roversPackage gains:
  - function clog2-based ACC_W(osr);
  - typedef rail_word_t (OUT_W-bit logic vector);
  - constant SINC_ORDER = 3.
- Sub-module sinc3_channel holds the per-channel integrators, combs and scaling, driven by tick/dec.
- One sinc3_channel is instantiated per channel in a generate loop.
- The top level owns the synchronisers, decimation counter, settle logic, watchdog and thresholds.

Test Plan:
- Constant sdat=all-1 on ch0 and all-0 on ch1, mclk=sclk/8, OSR=64:
  - first data_ready after the 3rd frame;
  - then out_data[0]=65535 and out_data[1]=0 every 512 sclk cycles.
- Alternating 1010 on all channels:
  - settled out_data = 32768 ±1 on every channel;
  - data_ready is exactly one cycle wide.
- ch2 at 75 % density, thr_hi[2]=40000:
  - over_flag[2] sets on the first settled word and stays set while the density drops to 25 %;
  - fault_clr clears it.
  - fault_clr in the same cycle as a new violation leaves it set.
- Stop mclk for 1100 cycles:
  - mclk_lost rises at the 1024th idle cycle and data_ready stops;
  - after mclk resumes, mclk_lost=0 and data_ready returns after 3 frames with correct values.
- Assert rst mid-frame:
  - outputs go to 0 asynchronously;
  - after release, the first data_ready comes 3 full frames later.
- Build without RAIL_MONITOR_FAULT_EN:
  - repeat the threshold scenario; flags remain 0 and out_data matches the build with the macro defined.
